aes_round_sequencer: RTL and testbench
======================================

# aes_round_sequencer

Parametrised control FSM for the iterative AES core, sequencing plaintext load, key load, initial AddRoundKey, the round loop and ciphertext readout. It drives the state-matrix write/read selects, the datapath operation select and the round-key index. It supports AES-128/192/256, encryption and decryption, and 1/2/4 columns per cycle. It sits between the host-facing strobes and the state matrix, key expansion unit and round datapath.

## Interface
- LANES, 1: rows/columns processed per beat; legal values 1, 2, 4. Beats per step B = 4/LANES.
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start_write_n  in  1  active-low load/encrypt request
- start_read_n  in  1  active-low ciphertext readout request
- key_size  in  2  00=128 (Nr=10, Nk=4), 01=192 (12, 6), 10=256 (14, 8), 11 treated as 00
- decrypt  in  1  1=inverse cipher
- key_expand_done  in  1  round keys ready (level)
- op_sel  out  4  0 load, 1 SubBytes, 2 ShiftRows, 3 MixColumns, 4 AddRoundKey, 5 InvSubBytes, 6 InvShiftRows, 7 InvMixColumns
- mat_we  out  1  state-matrix write enable
- in_row_col / out_row_col  out  1  0 row, 1 column
- in_idx / out_idx  out  2  base row/column index of the beat (beat*LANES)
- key_start  out  1  one-cycle key-expansion start
- key_word_idx  out  3  key word being written
- round_key_idx  out  4  round key used by AddRoundKey
- busy  out  1  high outside IDLE and DONE
- done  out  1  high in DONE
- dbg_state  out  4  current state code
- dbg_round  out  4  current round

## Operation
- Reset: all outputs 0, state IDLE, round 0, beat 0, mode registers 128/encrypt.
- IDLE: when start_write_n=0, latch key_size and decrypt, then go to PT_WRITE. All other inputs are ignored.
- PT_WRITE: B beats, op_sel=0, mat_we=1, columns. Then KEY_WRITE.
- KEY_WRITE: Nk beats, one word per beat. key_word_idx=beat. key_start=1 on beat 0 only. mat_we=0. Then WAIT_KEYS.
- WAIT_KEYS: minimum 1 cycle. Leave when key_expand_done=1 is sampled, then go to INIT_ARK. There is no timeout.
- INIT_ARK: B beats, AddRoundKey on columns. round_key_idx is 0 for encrypt and Nr for decrypt. Then round=1.
- Encrypt round r: SUBBYTES (rows), SHIFTROWS (rows), MIXCOLUMNS (columns; skipped when r=Nr), ARK (columns, round_key_idx=r).
- Decrypt round r: INV_SHIFTROWS, INV_SUBBYTES, ARK (round_key_idx=Nr−r), INV_MIXCOLUMNS (skipped when r=Nr).
- Each step is B beats with mat_we=1 and in_idx=out_idx=beat*LANES.
- After the last step of round r<Nr: round++, return to the first round step. After round Nr: DONE.
- DONE: done=1, mat_we=0. Stay until start_read_n=0, then CT_READ. start_write_n is ignored in DONE.
- CT_READ: B beats, out_row_col=1, out_idx=beat*LANES, mat_we=0. Then IDLE, round=0.
- Illegal state codes go to IDLE with all counters cleared.
- Round counter is 4 bits and never exceeds 14. Beat counter is 3 bits and wraps to 0 on every state change.

## Timing
- All outputs are registered-state decodes: combinational from current state, beat and round, with no input-to-output paths.
- Start sampled in cycle 0 puts PT_WRITE in cycle 1.
- Latency from start to done, with W = cycles spent in WAIT_KEYS (≥1): 1 + B + Nk + W + B + Nr·(4B) − B.
  - AES-128, LANES=1, W=1: 1+4+4+1+4+156 = 170 cycles.
- If key_expand_done is already high on entry to WAIT_KEYS, W=1.
- Deasserting reset_n in any state aborts immediately: outputs go to reset values and there is no pending done.
- Mode inputs are only sampled on the IDLE→PT_WRITE transition. Mid-run changes have no effect.
- Start strobes are level-sampled. A strobe held low spanning IDLE re-entry starts a new run.

## Configuration
- AES_SEQ_DBG_EN defined: dbg_state and dbg_round carry the state code and current round.
- AES_SEQ_DBG_EN undefined: both ports are tied to 0 and their decode logic is removed. All other behaviour is identical.

## Test plan
- LANES=1, key_size=00, encrypt, key_expand_done high from reset, start pulse:
  - done rises 170 cycles after start.
  - Exactly 9 MIXCOLUMNS steps occur.
  - round_key_idx on ARKs follows 0,1..10.
- LANES=4, key_size=10, decrypt:
  - Each step lasts 1 cycle.
  - KEY_WRITE lasts 8 cycles.
  - ARK indices follow 14,13..0.
  - No INV_MIXCOLUMNS occurs in round 14.
- key_expand_done held low for 20 cycles after WAIT_KEYS entry: the FSM stays in WAIT_KEYS with mat_we=0, then proceeds one cycle after assertion.
- In DONE, assert start_write_n low for 5 cycles: state is unchanged. Then assert start_read_n low: CT_READ emits out_idx 0,1,2,3 (LANES=1) and the FSM returns to IDLE.
- reset_n pulsed low during round 5 SHIFTROWS beat 2: outputs go to 0 asynchronously. A new start runs a full, correct sequence.
- key_size=11 with LANES=2: behaves as AES-128 with 10 rounds and 2-beat steps.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// rtl/aes_round_sequencer.sv - iterative AES control FSM; define AES_SEQ_DBG_EN to expose dbg_state_o/dbg_round_o
module aes_round_sequencer #(
    parameter int LANES = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_write_n_i,
    input  logic       start_read_n_i,
    input  logic [1:0] key_size_i,
    input  logic       decrypt_i,
    input  logic       key_expand_done_i,
    output logic [3:0] op_sel_o,
    output logic       mat_we_o,
    output logic       in_row_col_o,
    output logic       out_row_col_o,
    output logic [1:0] in_idx_o,
    output logic [1:0] out_idx_o,
    output logic       key_start_o,
    output logic [2:0] key_word_idx_o,
    output logic [3:0] round_key_idx_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] dbg_state_o,
    output logic [3:0] dbg_round_o
);

    // Beat index scales to a row/column base by LANES (1, 2 or 4).
    localparam int         SHIFT     = (LANES == 4) ? 2 : ((LANES == 2) ? 1 : 0);
    localparam logic [2:0] LAST_BEAT = 3'((4 / LANES) - 1);

    typedef enum logic [3:0] {
        S_IDLE           = 4'd0,
        S_PT_WRITE       = 4'd1,
        S_KEY_WRITE      = 4'd2,
        S_WAIT_KEYS      = 4'd3,
        S_INIT_ARK       = 4'd4,
        S_SUBBYTES       = 4'd5,
        S_SHIFTROWS      = 4'd6,
        S_MIXCOLUMNS     = 4'd7,
        S_ARK            = 4'd8,
        S_INV_SHIFTROWS  = 4'd9,
        S_INV_SUBBYTES   = 4'd10,
        S_INV_MIXCOLUMNS = 4'd11,
        S_DONE           = 4'd12,
        S_CT_READ        = 4'd13
    } state_t;

    state_t     state_q;
    logic [2:0] beat_q;
    logic [3:0] round_q;
    logic [1:0] ks_q;
    logic       dec_q;

    logic [3:0] nr;
    logic [2:0] nk_last;
    logic       step_last;
    logic       last_round;
    logic [1:0] beat_idx;
    logic [3:0] ark_idx;

    // Round count and key length from the latched key size (11 was folded to 00 at latch time).
    always_comb begin
        nr      = 4'd10;
        nk_last = 3'd3;
        case (ks_q)
            2'b01: begin
                nr      = 4'd12;
                nk_last = 3'd5;
            end
            2'b10: begin
                nr      = 4'd14;
                nk_last = 3'd7;
            end
            default: begin
                nr      = 4'd10;
                nk_last = 3'd3;
            end
        endcase
    end

    assign step_last  = (beat_q == LAST_BEAT);
    assign last_round = (round_q == nr);
    assign beat_idx   = beat_q[1:0] << SHIFT;
    assign ark_idx    = dec_q ? (nr - round_q) : round_q;

    // Sequencer: state, beat and round counters plus latched mode; beat restarts on every state change.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            beat_q  <= 3'd0;
            round_q <= 4'd0;
            ks_q    <= 2'b00;
            dec_q   <= 1'b0;
        end else begin
            beat_q <= beat_q + 3'd1;
            case (state_q)
                S_IDLE: begin
                    beat_q <= 3'd0;
                    if (!start_write_n_i) begin
                        ks_q    <= (key_size_i == 2'b11) ? 2'b00 : key_size_i;
                        dec_q   <= decrypt_i;
                        state_q <= S_PT_WRITE;
                    end
                end
                S_PT_WRITE: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        state_q <= S_KEY_WRITE;
                    end
                end
                S_KEY_WRITE: begin
                    if (beat_q == nk_last) begin
                        beat_q  <= 3'd0;
                        state_q <= S_WAIT_KEYS;
                    end
                end
                S_WAIT_KEYS: begin
                    beat_q <= 3'd0;
                    if (key_expand_done_i) begin
                        state_q <= S_INIT_ARK;
                    end
                end
                S_INIT_ARK: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        round_q <= 4'd1;
                        state_q <= dec_q ? S_INV_SHIFTROWS : S_SUBBYTES;
                    end
                end
                S_SUBBYTES: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        state_q <= S_SHIFTROWS;
                    end
                end
                S_SHIFTROWS: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        state_q <= last_round ? S_ARK : S_MIXCOLUMNS;
                    end
                end
                S_MIXCOLUMNS: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        state_q <= S_ARK;
                    end
                end
                S_ARK: begin
                    if (step_last) begin
                        beat_q <= 3'd0;
                        if (last_round) begin
                            state_q <= S_DONE;
                        end else if (dec_q) begin
                            state_q <= S_INV_MIXCOLUMNS;
                        end else begin
                            round_q <= round_q + 4'd1;
                            state_q <= S_SUBBYTES;
                        end
                    end
                end
                S_INV_SHIFTROWS: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        state_q <= S_INV_SUBBYTES;
                    end
                end
                S_INV_SUBBYTES: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        state_q <= S_ARK;
                    end
                end
                S_INV_MIXCOLUMNS: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        round_q <= round_q + 4'd1;
                        state_q <= S_INV_SHIFTROWS;
                    end
                end
                S_DONE: begin
                    beat_q <= 3'd0;
                    if (!start_read_n_i) begin
                        state_q <= S_CT_READ;
                    end
                end
                S_CT_READ: begin
                    if (step_last) begin
                        beat_q  <= 3'd0;
                        round_q <= 4'd0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    beat_q  <= 3'd0;
                    round_q <= 4'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state, beat and round only; no input reaches an output.
    always_comb begin
        op_sel_o        = 4'd0;
        mat_we_o        = 1'b0;
        in_row_col_o    = 1'b0;
        out_row_col_o   = 1'b0;
        in_idx_o        = 2'd0;
        out_idx_o       = 2'd0;
        key_start_o     = 1'b0;
        key_word_idx_o  = 3'd0;
        round_key_idx_o = 4'd0;
        busy_o          = (state_q != S_IDLE) && (state_q != S_DONE);
        done_o          = (state_q == S_DONE);
        case (state_q)
            S_PT_WRITE: begin
                mat_we_o     = 1'b1;
                in_row_col_o = 1'b1;
                in_idx_o     = beat_idx;
            end
            S_KEY_WRITE: begin
                key_word_idx_o = beat_q;
                key_start_o    = (beat_q == 3'd0);
            end
            S_INIT_ARK, S_ARK, S_MIXCOLUMNS, S_INV_MIXCOLUMNS: begin
                mat_we_o      = 1'b1;
                in_row_col_o  = 1'b1;
                out_row_col_o = 1'b1;
                in_idx_o      = beat_idx;
                out_idx_o     = beat_idx;
                if (state_q == S_MIXCOLUMNS) begin
                    op_sel_o = 4'd3;
                end else if (state_q == S_INV_MIXCOLUMNS) begin
                    op_sel_o = 4'd7;
                end else begin
                    op_sel_o        = 4'd4;
                    round_key_idx_o = (state_q == S_INIT_ARK) ? (dec_q ? nr : 4'd0) : ark_idx;
                end
            end
            S_SUBBYTES, S_SHIFTROWS, S_INV_SHIFTROWS, S_INV_SUBBYTES: begin
                mat_we_o  = 1'b1;
                in_idx_o  = beat_idx;
                out_idx_o = beat_idx;
                case (state_q)
                    S_SUBBYTES:      op_sel_o = 4'd1;
                    S_SHIFTROWS:     op_sel_o = 4'd2;
                    S_INV_SUBBYTES:  op_sel_o = 4'd5;
                    default:         op_sel_o = 4'd6;
                endcase
            end
            S_CT_READ: begin
                out_row_col_o = 1'b1;
                out_idx_o     = beat_idx;
            end
            default: begin
                op_sel_o = 4'd0;
            end
        endcase
    end

`ifdef AES_SEQ_DBG_EN
    assign dbg_state_o = state_q;
    assign dbg_round_o = round_q;
`else
    assign dbg_state_o = 4'd0;
    assign dbg_round_o = 4'd0;
`endif

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb/tb_aes_round_sequencer.sv - directed bench for aes_round_sequencer at LANES 1, 2 and 4
`timescale 1ns/1ps
module tb_aes_round_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       swr_n [3];
    logic       srd_n [3];
    logic [1:0] ks    [3];
    logic       dec   [3];
    logic       ked   [3];

    logic [3:0] op_sel    [3];
    logic       mat_we    [3];
    logic       in_rc     [3];
    logic       out_rc    [3];
    logic [1:0] in_idx    [3];
    logic [1:0] out_idx   [3];
    logic       key_start [3];
    logic [2:0] kw_idx    [3];
    logic [3:0] rk_idx    [3];
    logic       busy      [3];
    logic       done      [3];
    logic [3:0] dbg_state [3];
    logic [3:0] dbg_round [3];

    // Instance 0: LANES=1, instance 1: LANES=2, instance 2: LANES=4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_sequencer #(.LANES((g == 0) ? 1 : ((g == 1) ? 2 : 4))) u_dut (
            .clock             (clock),
            .reset_n           (reset_n),
            .start_write_n_i   (swr_n[g]),
            .start_read_n_i    (srd_n[g]),
            .key_size_i        (ks[g]),
            .decrypt_i         (dec[g]),
            .key_expand_done_i (ked[g]),
            .op_sel_o          (op_sel[g]),
            .mat_we_o          (mat_we[g]),
            .in_row_col_o      (in_rc[g]),
            .out_row_col_o     (out_rc[g]),
            .in_idx_o          (in_idx[g]),
            .out_idx_o         (out_idx[g]),
            .key_start_o       (key_start[g]),
            .key_word_idx_o    (kw_idx[g]),
            .round_key_idx_o   (rk_idx[g]),
            .busy_o            (busy[g]),
            .done_o            (done[g]),
            .dbg_state_o       (dbg_state[g]),
            .dbg_round_o       (dbg_round[g])
        );
    end

    int checks = 0;
    int errors = 0;

    int lat, mix_steps, mix_cyc, invmix_cyc, kw_cnt, wait_cnt, repeats, nz_idx, last_op;
    int ark_q [$];

    function automatic logic [28:0] out_vec(input int d);
        return {op_sel[d], mat_we[d], in_rc[d], out_rc[d], in_idx[d], out_idx[d], key_start[d],
                kw_idx[d], rk_idx[d], busy[d], done[d], dbg_state[d], dbg_round[d]};
    endfunction

    // Start one run on instance d and gather per-cycle statistics until done.
    task automatic run_seq(input int d, input logic [1:0] ksz, input logic dz, input int hold);
        int  n;
        logic [3:0] prev_op;
        logic prev_dp, dp, got;
        lat = 0; mix_steps = 0; mix_cyc = 0; invmix_cyc = 0; kw_cnt = 0;
        wait_cnt = 0; repeats = 0; nz_idx = 0; last_op = -1;
        ark_q.delete();
        ks[d] = ksz; dec[d] = dz; ked[d] = (hold == 0);
        @(negedge clock);
        swr_n[d] = 1'b0;
        n = 0; prev_op = 4'd0; prev_dp = 1'b0; got = 1'b0;
        while (n < 400) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (n == 1) begin
                swr_n[d] = 1'b1;
                ks[d]    = ~ksz;
                dec[d]   = ~dz;
            end
            if (done[d]) begin
                got = 1'b1;
                break;
            end
            if (mat_we[d] && op_sel[d] == 4'd3) begin
                mix_cyc++;
                if (in_idx[d] == 2'd0) mix_steps++;
            end
            if (mat_we[d] && op_sel[d] == 4'd7) invmix_cyc++;
            if (mat_we[d] && op_sel[d] == 4'd4 && in_idx[d] == 2'd0) ark_q.push_back(int'(rk_idx[d]));
            if (key_start[d] || kw_idx[d] != 3'd0) kw_cnt++;
            if (busy[d] && !mat_we[d] && !key_start[d] && kw_idx[d] == 3'd0) begin
                wait_cnt++;
                if (hold > 0 && wait_cnt == hold) ked[d] = 1'b1;
            end
            dp = mat_we[d] && (op_sel[d] != 4'd0);
            if (dp && prev_dp && op_sel[d] == prev_op) repeats++;
            if (in_idx[d] != 2'd0) nz_idx++;
            if (busy[d]) last_op = int'(op_sel[d]);
            prev_dp = dp;
            prev_op = op_sel[d];
        end
        lat = n;
        ked[d] = 1'b1;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL run_timeout inst=%0d: done not seen within %0d cycles", d, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            swr_n[i] = 1'b1; srd_n[i] = 1'b1; ks[i] = 2'b00; dec[i] = 1'b0; ked[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_vec(i) !== 29'd0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d: got %h expected 0", i, out_vec(i));
            end
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_enc128();
        run_seq(0, 2'b00, 1'b0, 0);
        checks++; if (lat !== 170) begin errors++; $display("FAIL enc128_latency: got %0d expected 170", lat); end
        checks++; if (mix_steps !== 9) begin errors++; $display("FAIL enc128_mix_steps: got %0d expected 9", mix_steps); end
        checks++; if (mix_cyc !== 36) begin errors++; $display("FAIL enc128_mix_cycles: got %0d expected 36", mix_cyc); end
        checks++; if (kw_cnt !== 4) begin errors++; $display("FAIL enc128_key_write: got %0d expected 4", kw_cnt); end
        checks++; if (wait_cnt !== 1) begin errors++; $display("FAIL enc128_wait: got %0d expected 1", wait_cnt); end
        checks++;
        if (ark_q.size() !== 11) begin
            errors++; $display("FAIL enc128_ark_count: got %0d expected 11", ark_q.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (ark_q[i] !== i) begin errors++; $display("FAIL enc128_ark_idx[%0d]: got %0d expected %0d", i, ark_q[i], i); end
            end
        end
    endtask

    task automatic test_done_ct_read();
        swr_n[0] = 1'b0;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if ({done[0], busy[0], mat_we[0]} !== 3'b100) begin
                errors++; $display("FAIL done_hold: got done/busy/we=%b expected 100", {done[0], busy[0], mat_we[0]});
            end
        end
        swr_n[0] = 1'b1;
        srd_n[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] e;
            e = 2'(i);
            @(posedge clock);
            @(negedge clock);
            srd_n[0] = 1'b1;
            checks++;
            if ({busy[0], out_rc[0], mat_we[0], out_idx[0]} !== {1'b1, 1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL ct_read_beat%0d: got busy/rc/we/idx=%b expected %b", i,
                         {busy[0], out_rc[0], mat_we[0], out_idx[0]}, {1'b1, 1'b1, 1'b0, e});
            end
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({busy[0], done[0]} !== 2'b00) begin
            errors++; $display("FAIL ct_read_to_idle: got busy/done=%b expected 00", {busy[0], done[0]});
        end
    endtask

    task automatic test_key_wait();
        run_seq(0, 2'b00, 1'b0, 20);
        checks++; if (wait_cnt !== 20) begin errors++; $display("FAIL keywait_cycles: got %0d expected 20", wait_cnt); end
        checks++; if (lat !== 189) begin errors++; $display("FAIL keywait_latency: got %0d expected 189", lat); end
        // return instance 0 to IDLE
        srd_n[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        srd_n[0] = 1'b1;
        repeat (5) @(negedge clock);
        checks++;
        if (busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            errors++; $display("FAIL keywait_readout_idle: got busy=%b done=%b expected 0 0", busy[0], done[0]);
        end
    endtask

    task automatic test_reset_midrun();
        int  sr;
        logic found;
        ks[0] = 2'b00; dec[0] = 1'b0; ked[0] = 1'b1;
        sr = 0; found = 1'b0;
        @(negedge clock);
        swr_n[0] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        swr_n[0] = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (mat_we[0] && op_sel[0] == 4'd2 && in_idx[0] == 2'd0) sr++;
            if (sr == 5 && op_sel[0] == 4'd2 && in_idx[0] == 2'd2) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL midrun_reach_r5_sr_b2: got %b expected 1", found); end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (out_vec(0) !== 29'd0) begin
            errors++; $display("FAIL midrun_async_reset: got %h expected 0", out_vec(0));
        end
        @(negedge clock);
        reset_n = 1'b1;
        run_seq(0, 2'b00, 1'b0, 0);
        checks++; if (lat !== 170) begin errors++; $display("FAIL post_reset_latency: got %0d expected 170", lat); end
        checks++;
        if (ark_q.size() !== 11 || ark_q[10] !== 10 || ark_q[0] !== 0) begin
            errors++; $display("FAIL post_reset_ark: got size %0d expected 11 entries 0..10", ark_q.size());
        end
    endtask

    task automatic test_dec256_lanes4();
        run_seq(2, 2'b10, 1'b1, 0);
        checks++; if (lat !== 67) begin errors++; $display("FAIL dec256_latency: got %0d expected 67", lat); end
        checks++; if (kw_cnt !== 8) begin errors++; $display("FAIL dec256_key_write: got %0d expected 8", kw_cnt); end
        checks++; if (repeats !== 0) begin errors++; $display("FAIL dec256_step_len: got %0d repeats expected 0", repeats); end
        checks++; if (invmix_cyc !== 13) begin errors++; $display("FAIL dec256_invmix: got %0d expected 13", invmix_cyc); end
        checks++; if (last_op !== 4) begin errors++; $display("FAIL dec256_last_op: got %0d expected 4", last_op); end
        checks++; if (nz_idx !== 0) begin errors++; $display("FAIL dec256_idx_nonzero: got %0d expected 0", nz_idx); end
        checks++;
        if (ark_q.size() !== 15) begin
            errors++; $display("FAIL dec256_ark_count: got %0d expected 15", ark_q.size());
        end else begin
            for (int i = 0; i < 15; i++) begin
                checks++;
                if (ark_q[i] !== 14 - i) begin errors++; $display("FAIL dec256_ark_idx[%0d]: got %0d expected %0d", i, ark_q[i], 14 - i); end
            end
        end
    endtask

    task automatic test_ks11_lanes2();
        run_seq(1, 2'b11, 1'b0, 0);
        checks++; if (lat !== 88) begin errors++; $display("FAIL ks11_latency: got %0d expected 88", lat); end
        checks++; if (mix_steps !== 9) begin errors++; $display("FAIL ks11_mix_steps: got %0d expected 9", mix_steps); end
        checks++; if (mix_cyc !== 18) begin errors++; $display("FAIL ks11_mix_cycles: got %0d expected 18", mix_cyc); end
        checks++; if (kw_cnt !== 4) begin errors++; $display("FAIL ks11_key_write: got %0d expected 4", kw_cnt); end
        checks++;
        if (ark_q.size() !== 11) begin
            errors++; $display("FAIL ks11_ark_count: got %0d expected 11", ark_q.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (ark_q[i] !== i) begin errors++; $display("FAIL ks11_ark_idx[%0d]: got %0d expected %0d", i, ark_q[i], i); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_enc128();
        test_done_ct_read();
        test_key_wait();
        test_reset_midrun();
        test_dec256_lanes4();
        test_ks11_lanes2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
